// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle accumulator CPU.
// Sequences fetch/decode/memory/execute and counts retired instructions.
module multicycle_controller #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_ready,
    input  logic [3:0]         instr_op,
    input  logic               acc_zero,
    output logic               mem_req,
    output logic               mem_we,
    output logic               addr_sel,
    output logic               ir_write,
    output logic               pc_inc,
    output logic               pc_load,
    output logic               mdr_write,
    output logic               acc_write,
    output logic               acc_src,
    output logic               alu_src,
    output logic [3:0]         alu_opcode,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_RD,
        S_MEM_WR,
        S_WB,
        S_EXEC_R,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic                 started_q;
    logic [3:0]           op_q;
    logic [COUNT_W-1:0]   cnt_q;
    logic                 retire;

    logic is_lda, is_sta, is_ada, is_ana;
    logic is_jmp, is_bz, is_reg, is_hlt;

    // Opcode class decode from the latched opcode
    always_comb begin
        is_lda = (op_q[3:1] == 3'b000);
        is_sta = (op_q[3:1] == 3'b001);
        is_ada = (op_q[3:1] == 3'b010);
        is_ana = (op_q[3:1] == 3'b011);
        is_jmp = (op_q[3:1] == 3'b100);
        is_bz  = (op_q[3:1] == 3'b101);
        is_hlt = (op_q == 4'b1111);
        is_reg = (op_q[3:2] == 2'b11) && !is_hlt;
    end

    // Next-state logic and retirement detection
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_lda || is_ada || is_ana) begin
                    state_d = S_MEM_RD;
                end else if (is_sta) begin
                    state_d = S_MEM_WR;
                end else if (is_reg) begin
                    state_d = S_EXEC_R;
                end else if (is_hlt) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC_R: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Datapath strobes; silent until the first cycle after reset release
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        mdr_write = 1'b0;
        acc_write = 1'b0;
        acc_src   = 1'b0;
        alu_src   = 1'b0;
        halted    = 1'b0;
        if (started_q) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_inc   = mem_ready;
                end
                S_DECODE: begin
                    pc_load = is_jmp || (is_bz && acc_zero);
                end
                S_MEM_RD: begin
                    mem_req   = 1'b1;
                    addr_sel  = 1'b1;
                    mdr_write = mem_ready;
                end
                S_MEM_WR: begin
                    mem_req  = 1'b1;
                    mem_we   = 1'b1;
                    addr_sel = 1'b1;
                end
                S_WB: begin
                    acc_write = 1'b1;
                    acc_src   = is_lda;
                    alu_src   = !is_lda;
                end
                S_EXEC_R: begin
                    acc_write = 1'b1;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                    halted = 1'b0;
                end
            endcase
        end
    end

    // State, opcode latch and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            started_q <= 1'b0;
            op_q      <= 4'b0000;
            cnt_q     <= '0;
        end else begin
            started_q <= 1'b1;
            if (started_q) begin
                state_q <= state_d;
                if (state_q == S_FETCH && mem_ready) begin
                    op_q <= instr_op;
                end
                if (retire) begin
                    cnt_q <= cnt_q + COUNT_W'(1);
                end
            end
        end
    end

    assign alu_opcode  = op_q;
    assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM of the multicycle accumulator CPU. It sequences fetch, decode, memory access and execute over a single shared memory with a ready handshake. It latches the instruction opcode and drives it to the ALU controller, which sits directly downstream of this block. It also drives all datapath write enables and mux selects, and counts retired instructions.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_ready  in  1  memory completes current request this cycle
- instr_op  in  4  mem_rdata[15:12], valid when FETCH and mem_ready
- acc_zero  in  1  accumulator == 0 flag from datapath
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (STA), 0 = read
- addr_sel  out  1  0 = PC, 1 = IR address field
- ir_write  out  1  load IR from mem_rdata
- pc_inc  out  1  PC <= PC + 1
- pc_load  out  1  PC <= IR address field
- mdr_write  out  1  load MDR from mem_rdata
- acc_write  out  1  accumulator write enable
- acc_src  out  1  0 = ALU result, 1 = MDR
- alu_src  out  1  0 = register file (IR[1:0]), 1 = MDR
- alu_opcode  out  4  latched opcode to ALU controller
- halted  out  1  FSM in HALT
- instr_count  out  COUNT_W  retired instructions

## Operation
- Opcode map, 3-bit prefix, op[0] belongs to the address:
  - 000x LDA
  - 001x STA
  - 010x ADA
  - 011x ANA
  - 100x JMP
  - 101x BZ
- Opcode map, full 4-bit:
  - 1100 ADR
  - 1101 ANR
  - 1110 ORR
  - 1111 HLT
- All 16 encodings are legal.
- States: FETCH, DECODE, MEM_RD, MEM_WR, WB, EXEC_R, HALT.
- FETCH:
  - Asserts mem_req=1, addr_sel=0, mem_we=0.
  - On mem_ready: ir_write=1 and pc_inc=1 in the same cycle; alu_opcode <= instr_op; go to DECODE.
  - Without mem_ready: stay in FETCH.
- DECODE (always one cycle):
  - LDA/ADA/ANA -> MEM_RD.
  - STA -> MEM_WR.
  - ADR/ANR/ORR -> EXEC_R.
  - JMP: pc_load=1 -> FETCH.
  - BZ: pc_load=acc_zero -> FETCH.
  - HLT -> HALT.
- MEM_RD: mem_req=1, addr_sel=1. On mem_ready: mdr_write=1 -> WB.
- WB:
  - acc_write=1 -> FETCH.
  - LDA: acc_src=1.
  - ADA/ANA: acc_src=0, alu_src=1.
- MEM_WR: mem_req=1, mem_we=1, addr_sel=1. On mem_ready -> FETCH.
- EXEC_R: acc_write=1, acc_src=0, alu_src=0 -> FETCH.
- HALT: all strobes 0, halted=1. Only reset leaves HALT.
- instr_count:
  - +1 on the cycle an instruction completes: the transition into FETCH from DECODE/WB/MEM_WR/EXEC_R, and the DECODE->HALT transition.
  - Wraps from all-ones to 0.
- Strobes ir_write, pc_inc, mdr_write and the MEM_WR exit are combinational on mem_ready (Mealy). All other outputs are decoded from state only.

## Timing
- Reset (async, rst_n=0):
  - State = FETCH, alu_opcode = 4'b0000, instr_count = 0.
  - All strobes = 0, halted = 0.
  - mem_req rises only after rst_n deasserts, registered in FETCH.
- Reset mid-memory-access: mem_req drops immediately and the pending request is abandoned; after reset the FSM restarts FETCH.
- Handshake:
  - mem_req, mem_we and addr_sel are held constant until the cycle mem_ready=1 is sampled.
  - mem_ready in the first request cycle is legal (zero wait).
  - mem_ready outside a request state is ignored.
- Latency with zero-wait memory:
  - JMP/BZ: 2 cycles.
  - ADR/ANR/ORR, STA: 3 cycles.
  - LDA/ADA/ANA: 4 cycles.
  - Each wait state adds 1 cycle.
- alu_opcode changes only on FETCH completion and is stable through DECODE/WB/EXEC_R.
- BZ samples acc_zero in DECODE only.

## Test plan
- Reset then ADR (1100) with mem_ready tied 1 -> states FETCH, DECODE, EXEC_R; acc_write high in cycle 3; alu_opcode=1100; instr_count=1.
- LDA with 2 wait states per access -> mem_req held 3 cycles in FETCH and 3 in MEM_RD, address/we stable throughout; WB has acc_src=1; total 8 cycles.
- BZ twice, with acc_zero=1 then acc_zero=0 -> pc_load pulses in DECODE only for the first; both complete in 2 cycles.
- STA then HLT -> mem_we=1 only in MEM_WR; halted=1 from the cycle after DECODE; further mem_ready pulses give no strobes; instr_count=2.
- Assert rst_n=0 mid-MEM_RD -> mem_req=0 in the same cycle, alu_opcode=0, count=0; after release, FETCH issues mem_req with addr_sel=0.
- COUNT_W=4, run 17 ADR instructions -> instr_count wraps 15->0 and ends at 1.
